seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 197 +++++++++++++++++++
 tb/tb_seq_alu.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with valid/ready handshake and shift-add multiplier
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             unsig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             compout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 ready_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2:0]           op_q;
  logic                 unsig_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     mres_q, mres_d;
  logic                 movf_q, movf_d;

  logic                 accept;
  logic [WIDTH:0]       add_full, sub_full;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mac_sum;
  logic [2*WIDTH-1:0]   mac_prod, mul_signed;
  logic [WIDTH-1:0]     mul_hi, mul_lo;
  logic                 mul_ovf;

  // ready_q keeps in_ready low until the first edge after reset is released
  assign in_ready  = (state_q == IDLE) && ready_q;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // operand capture at the accepting edge; held through BUSY and DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      unsig_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      unsig_q <= unsig;
    end
  end

  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};

  // single-cycle ops evaluated from held operands; MUL reads its result register
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_XOR: alu_res = a_q ^ b_q;
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_ovf = unsig_q ? add_full[WIDTH]
                          : ((a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (add_full[WIDTH-1] != a_q[WIDTH-1]));
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_ovf = unsig_q ? sub_full[WIDTH]
                          : ((a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (sub_full[WIDTH-1] != a_q[WIDTH-1]));
      end
      OP_MUL: begin
        alu_res = mres_q;
        alu_ovf = movf_q;
      end
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  assign result   = alu_res;
  assign overflow = alu_ovf;
  assign zero     = (alu_res == '0);
  assign compout  = unsig_q ? (a_q < b_q) : ($signed(a_q) < $signed(b_q));

  // magnitudes for the multiplier; unsigned mode uses the raw operands
  assign mag_a = (!unsig && a[WIDTH-1]) ? -a : a;
  assign mag_b = (!unsig && b[WIDTH-1]) ? -b : b;

  // one shift-add step: low half holds the remaining multiplier bits
  assign mac_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                      (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mac_prod   = {mac_sum, prod_q[WIDTH-1:1]};
  assign mul_signed = neg_q ? -mac_prod : mac_prod;
  assign mul_hi     = mul_signed[2*WIDTH-1:WIDTH];
  assign mul_lo     = mul_signed[WIDTH-1:0];
  assign mul_ovf    = unsig_q ? (|mul_hi) : (mul_hi != {WIDTH{mul_lo[WIDTH-1]}});

  // next-state and datapath updates for the three-state controller
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    mres_d  = mres_q;
    movf_d  = movf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d = BUSY;
            cnt_d   = CW'(WIDTH - 1);
            prod_d  = {{WIDTH{1'b0}}, mag_b};
            mcand_d = mag_a;
            neg_d   = !unsig && (a[WIDTH-1] ^ b[WIDTH-1]);
          end else begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        prod_d = mac_prod;
        if (cnt_q == '0) begin
          state_d = DONE;
          mres_d  = mul_lo;
          movf_d  = mul_ovf;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // controller and multiplier state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      mres_q  <= '0;
      movf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      mres_q  <= mres_d;
      movf_q  <= movf_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed and randomized checks of seq_alu at WIDTH 32 and 8
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv, un, ordy, sel8;
  logic [31:0] a, b;
  logic [2:0]  op;

  logic        iv32, iv8;
  logic        ir32, ov32, cmp32, ovf32, zr32;
  logic [31:0] res32;
  logic        ir8, ov8, cmp8, ovf8, zr8;
  logic [7:0]  res8;

  logic        s_ir, s_ov, s_cmp, s_ovf, s_zr;
  logic [31:0] s_res;

  int n_checks = 0;
  int n_fail   = 0;

  assign iv32  = iv & ~sel8;
  assign iv8   = iv & sel8;
  assign s_ir  = sel8 ? ir8  : ir32;
  assign s_ov  = sel8 ? ov8  : ov32;
  assign s_cmp = sel8 ? cmp8 : cmp32;
  assign s_ovf = sel8 ? ovf8 : ovf32;
  assign s_zr  = sel8 ? zr8  : zr32;
  assign s_res = sel8 ? {24'h0, res8} : res32;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a), .b(b), .op(op), .unsig(un),
    .out_valid(ov32), .out_ready(ordy), .result(res32),
    .compout(cmp32), .overflow(ovf32), .zero(zr32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .op(op), .unsig(un),
    .out_valid(ov8), .out_ready(ordy), .result(res8),
    .compout(cmp8), .overflow(ovf8), .zero(zr8)
  );

  // reference: arithmetic on wide integers with explicit range tests
  function automatic void model(input int w, input logic [63:0] x, input logic [63:0] y,
                                input logic [2:0] o, input logic u,
                                output logic [63:0] r, output logic f, output logic c);
    logic [63:0] mask, ux, uy, p;
    longint sx, sy, s, mx, mn;
    mask = (64'd1 << w) - 64'd1;
    ux = x & mask;
    uy = y & mask;
    sx = ux[w-1] ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
    sy = uy[w-1] ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    f = 1'b0;
    r = 64'd0;
    case (o)
      3'b000: r = ux & uy;
      3'b001: r = ux | uy;
      3'b100: r = ~(ux | uy) & mask;
      3'b101: r = ux ^ uy;
      3'b010: begin
        p = ux + uy; r = p & mask; s = sx + sy;
        f = u ? (p > mask) : (s > mx || s < mn);
      end
      3'b110: begin
        p = ux - uy; r = p & mask; s = sx - sy;
        f = u ? (ux < uy) : (s > mx || s < mn);
      end
      3'b111: begin
        if (u) begin
          p = ux * uy; f = (p > mask);
        end else begin
          s = sx * sy; p = s; f = (s > mx || s < mn);
        end
        r = p & mask;
      end
      default: r = 64'd0;
    endcase
    c = u ? (ux < uy) : (sx < sy);
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic u, output int lat, output logic [31:0] r,
                       output logic c, output logic f, output logic z);
    int k;
    k = 0;
    while (!s_ir && k < 100) begin @(negedge clk); k++; end
    iv = 1'b1; op = o; a = x; b = y; un = u;
    @(negedge clk);
    iv = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom); un = 1'($urandom);
    lat = 1;
    while (!s_ov && lat < 200) begin @(negedge clk); lat++; end
    r = s_res; c = s_cmp; f = s_ovf; z = s_zr;
  endtask

  task automatic pop();
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; sel8 = 1'b0;
    a = '0; b = '0; op = '0; un = 1'b0;
    #12;
    n_checks++; if (ir32 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", ir32); end
    n_checks++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", ov32); end
    n_checks++; if (res32 !== 32'h0) begin n_fail++; $display("FAIL rst_result got=%h exp=0", res32); end
    n_checks++; if (cmp32 !== 1'b0) begin n_fail++; $display("FAIL rst_compout got=%b exp=0", cmp32); end
    n_checks++; if (ovf32 !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got=%b exp=0", ovf32); end
    n_checks++; if (zr32 !== 1'b1) begin n_fail++; $display("FAIL rst_zero got=%b exp=1", zr32); end
    n_checks++; if (ir8 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready8 got=%b exp=0", ir8); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (ir32 !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_early got=%b exp=0", ir32); end
    @(negedge clk);
    n_checks++; if (ir32 !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got=%b exp=1", ir32); end
  endtask

  task automatic test_add_sub();
    logic [2:0]  vo[4] = '{3'b010, 3'b010, 3'b110, 3'b110};
    logic [31:0] va[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd0};
    logic [31:0] vb[4] = '{32'd1, 32'd1, 32'd5, 32'd1};
    logic        vu[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] er[4] = '{32'h80000000, 32'h80000000, 32'h0, 32'hFFFFFFFF};
    logic        ef[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        ec[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        ez[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat; logic [31:0] r; logic c, f, z;
    sel8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_op(vo[i], va[i], vb[i], vu[i], lat, r, c, f, z);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL addsub%0d_latency got=%0d exp=1", i, lat); end
      n_checks++; if (r !== er[i]) begin n_fail++; $display("FAIL addsub%0d_result got=%h exp=%h", i, r, er[i]); end
      n_checks++; if (f !== ef[i]) begin n_fail++; $display("FAIL addsub%0d_overflow got=%b exp=%b", i, f, ef[i]); end
      n_checks++; if (c !== ec[i]) begin n_fail++; $display("FAIL addsub%0d_compout got=%b exp=%b", i, c, ec[i]); end
      n_checks++; if (z !== ez[i]) begin n_fail++; $display("FAIL addsub%0d_zero got=%b exp=%b", i, z, ez[i]); end
      pop();
    end
  endtask

  task automatic test_logic();
    logic [2:0]  vo[5] = '{3'b000, 3'b001, 3'b101, 3'b100, 3'b011};
    logic [31:0] er[5] = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F, 32'h0};
    int lat; logic [31:0] r; logic c, f, z;
    sel8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_op(vo[i], 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, lat, r, c, f, z);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL logic%0d_latency got=%0d exp=1", i, lat); end
      n_checks++; if (r !== er[i]) begin n_fail++; $display("FAIL logic%0d_result got=%h exp=%h", i, r, er[i]); end
      n_checks++; if (f !== 1'b0) begin n_fail++; $display("FAIL logic%0d_overflow got=%b exp=0", i, f); end
      n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL logic%0d_compout got=%b exp=1", i, c); end
      n_checks++; if (z !== (er[i] == 32'h0)) begin n_fail++; $display("FAIL logic%0d_zero got=%b exp=%b", i, z, (er[i] == 32'h0)); end
      pop();
    end
  endtask

  task automatic test_mul();
    logic        v8[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] va[5] = '{32'hFFFFFFFD, 32'h00010000, 32'h80000000, 32'hFFFFFFFF, 32'h000000FD};
    logic [31:0] vb[5] = '{32'd7, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007};
    logic        vu[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] er[5] = '{32'hFFFFFFEB, 32'h0, 32'h80000000, 32'h00000001, 32'h000000EB};
    logic        ef[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        ec[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          el[5] = '{33, 33, 33, 33, 9};
    int lat; logic [31:0] r; logic c, f, z;
    for (int i = 0; i < 5; i++) begin
      sel8 = v8[i];
      do_op(3'b111, va[i], vb[i], vu[i], lat, r, c, f, z);
      n_checks++; if (lat !== el[i]) begin n_fail++; $display("FAIL mul%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
      n_checks++; if (r !== er[i]) begin n_fail++; $display("FAIL mul%0d_result got=%h exp=%h", i, r, er[i]); end
      n_checks++; if (f !== ef[i]) begin n_fail++; $display("FAIL mul%0d_overflow got=%b exp=%b", i, f, ef[i]); end
      n_checks++; if (c !== ec[i]) begin n_fail++; $display("FAIL mul%0d_compout got=%b exp=%b", i, c, ec[i]); end
      n_checks++; if (z !== (er[i] == 32'h0)) begin n_fail++; $display("FAIL mul%0d_zero got=%b exp=%b", i, z, (er[i] == 32'h0)); end
      pop();
    end
    sel8 = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] r; logic c, f, z;
    sel8 = 1'b0;
    do_op(3'b010, 32'd3, 32'd4, 1'b0, lat, r, c, f, z);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (s_ov !== 1'b1 || s_ir !== 1'b0 || s_res !== 32'd7 || s_zr !== 1'b0 || s_cmp !== 1'b1)
        begin n_fail++; $display("FAIL bp_hold%0d got ov=%b ir=%b res=%h exp ov=1 ir=0 res=7", i, s_ov, s_ir, s_res); end
    end
    pop();
    n_checks++; if (s_ov !== 1'b0 || s_ir !== 1'b1) begin n_fail++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", s_ov, s_ir); end
    do_op(3'b110, 32'd10, 32'd3, 1'b1, lat, r, c, f, z);
    n_checks++; if (r !== 32'd7 || lat !== 1) begin n_fail++; $display("FAIL bp_next got res=%h lat=%0d exp res=7 lat=1", r, lat); end
    pop();
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] r; logic c, f, z;
    sel8 = 1'b0;
    do_op(3'b010, 32'd1, 32'd2, 1'b0, lat, r, c, f, z);
    iv = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4; un = 1'b0; ordy = 1'b1;
    n_checks++; if (s_ir !== 1'b0) begin n_fail++; $display("FAIL b2b_no_accept_in_done got=%b exp=0", s_ir); end
    @(negedge clk);
    ordy = 1'b0;
    n_checks++; if (s_ov !== 1'b0 || s_ir !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got ov=%b ir=%b exp ov=0 ir=1", s_ov, s_ir); end
    @(negedge clk);
    iv = 1'b0;
    n_checks++; if (s_ov !== 1'b1 || s_res !== 32'd7) begin n_fail++; $display("FAIL b2b_second got ov=%b res=%h exp ov=1 res=7", s_ov, s_res); end
    pop();
  endtask

  task automatic test_reset_mid_mul();
    int k, lat; logic seen; logic [31:0] r; logic c, f, z;
    sel8 = 1'b0;
    k = 0;
    while (!s_ir && k < 100) begin @(negedge clk); k++; end
    iv = 1'b1; op = 3'b111; a = 32'hFFFFFFFD; b = 32'd7; un = 1'b0;
    @(negedge clk);
    iv = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ov32 !== 1'b0 || ir32 !== 1'b0) begin n_fail++; $display("FAIL midrst_immediate got ov=%b ir=%b exp 0 0", ov32, ir32); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ov32) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_out_valid got=%b exp=0", seen); end
    do_op(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, lat, r, c, f, z);
    n_checks++; if (r !== 32'hF000F000 || lat !== 1) begin n_fail++; $display("FAIL midrst_and got res=%h lat=%0d exp res=f000f000 lat=1", r, lat); end
    pop();
  endtask

  task automatic test_sweep(input logic w8, input int n);
    int k, w, hold;
    logic [2:0] o; logic [31:0] x, y; logic u;
    logic [63:0] er; logic ef, ec;
    sel8 = w8;
    w = w8 ? 8 : 32;
    for (int i = 0; i < n; i++) begin
      o = 3'($urandom_range(0, 7)); x = $urandom; y = $urandom; u = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) y = x;
      if ($urandom_range(0, 5) == 0) x = w8 ? 32'h80 : 32'h80000000;
      model(w, {32'h0, x}, {32'h0, y}, o, u, er, ef, ec);
      iv = 1'b0;
      repeat ($urandom_range(0, 2)) begin ordy = 1'($urandom_range(0, 1)); @(negedge clk); end
      a = x; b = y; op = o; un = u; iv = 1'b1;
      k = 0;
      while (!s_ir && k < 100) begin @(negedge clk); k++; end
      @(negedge clk);
      iv = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom); un = 1'($urandom);
      k = 0;
      while (!s_ov && k < 200) begin ordy = 1'($urandom_range(0, 1)); @(negedge clk); k++; end
      ordy = 1'b0;
      n_checks++; if (s_ov !== 1'b1 || s_res !== er[31:0] || s_ovf !== ef || s_cmp !== ec || s_zr !== (er[31:0] == 32'h0))
        begin n_fail++; $display("FAIL sweep%0d_%0d op=%0d a=%h b=%h u=%b got ov=%b res=%h ovf=%b cmp=%b exp res=%h ovf=%b cmp=%b",
                                 w, i, o, x, y, u, s_ov, s_res, s_ovf, s_cmp, er[31:0], ef, ec); end
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      n_checks++; if (s_ov !== 1'b1 || s_res !== er[31:0]) begin n_fail++; $display("FAIL sweep%0d_%0d_hold got ov=%b res=%h exp res=%h", w, i, s_ov, s_res, er[31:0]); end
      pop();
      n_checks++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL sweep%0d_%0d_pop got=%b exp=0", w, i, s_ov); end
    end
    sel8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_sweep(1'b0, 60);
    test_sweep(1'b1, 60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
